// File: rtl/sata_pkg.sv
// sata_pkg: shared SATA TX constants, frame-arbiter state encoding and grant decode.
package sata_pkg;

    localparam int unsigned SATA_MAXFIS_DW = 2048;
    localparam int unsigned ARB_CNT_W      = 12;
    localparam int unsigned ARB_SRC_N      = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT0  = 2'd1,
        ARB_GNT1  = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_t;

    // One-hot owner for a given state; DRAIN reports the source being drained.
    function automatic logic [ARB_SRC_N-1:0] arb_grant(input arb_state_t st, input logic drain_src);
        logic [ARB_SRC_N-1:0] g;
        g = '0;
        case (st)
            ARB_GNT0:  g = 2'b01;
            ARB_GNT1:  g = 2'b10;
            ARB_DRAIN: g = drain_src ? 2'b10 : 2'b01;
            default:   g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sata_axis_oreg.sv
// sata_axis_oreg: single-entry AXI-stream output register; holds word until taken.
// With OPT_LOWPOWER set, data/last read as zero whenever valid is low.
module sata_axis_oreg #(
    parameter int unsigned W            = 32,
    parameter bit          OPT_LOWPOWER = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready_c,
    input  logic [W-1:0] s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last
);

    // Space is available when empty or when the held word leaves this cycle.
    assign s_ready_c = !m_valid || m_ready;

    // Load on upstream handshake, otherwise drop valid once downstream takes the word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (s_valid && s_ready_c) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            if (OPT_LOWPOWER) begin
                m_data <= '0;
                m_last <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/satatx_frame_arbiter.sv
// satatx_frame_arbiter: frame-atomic two-source round-robin merge feeding satatx_scrambler.
// Optional length guard enabled by defining SATA_FRAMEARB_TRUNCATE_EN: frames longer than
// MAXLEN words are cut with a forced TLAST, the remainder drained, and o_err_trunc pulsed.
module satatx_frame_arbiter
    import sata_pkg::*;
#(
    parameter int unsigned W            = 32,
    parameter int unsigned MAXLEN       = SATA_MAXFIS_DW,
    parameter bit          OPT_LOWPOWER = 1'b0
) (
    input  logic         S_AXI_ACLK,
    input  logic         S_AXI_ARESETN,
    input  logic         S0_AXIS_TVALID,
    output logic         S0_AXIS_TREADY,
    input  logic [W-1:0] S0_AXIS_TDATA,
    input  logic         S0_AXIS_TLAST,
    input  logic         S1_AXIS_TVALID,
    output logic         S1_AXIS_TREADY,
    input  logic [W-1:0] S1_AXIS_TDATA,
    input  logic         S1_AXIS_TLAST,
    output logic         M_AXIS_TVALID,
    input  logic         M_AXIS_TREADY,
    output logic [W-1:0] M_AXIS_TDATA,
    output logic         M_AXIS_TLAST,
    output logic [1:0]   o_grant,
    output logic         o_err_trunc
);

    // Counter is 12 bits wide, so the frame limit must fit below its wrap point.
    if ((MAXLEN < 2) || (MAXLEN > 4095)) begin : g_bad_maxlen
        $error("satatx_frame_arbiter: MAXLEN must be in 2..4095");
    end

    arb_state_t           state;
    arb_state_t           state_next;
    logic                 last_src;
    logic [ARB_CNT_W-1:0] cnt;
    logic                 oreg_ready;
    logic                 sel_valid;
    logic                 sel_ready;
    logic [W-1:0]         sel_data;
    logic                 sel_last;
    logic                 cur_src;
    logic                 fwd_en;
    logic                 acc;
    logic                 fwd;
    logic                 trunc_hit;
    logic                 drain_src_next;

`ifdef SATA_FRAMEARB_TRUNCATE_EN
    localparam logic [ARB_CNT_W-1:0] CNT_LAST = ARB_CNT_W'(MAXLEN - 1);
    logic drain_src;

    // Cut point: word MAXLEN-1 forwarded without a natural TLAST.
    assign trunc_hit      = fwd && !sel_last && (cnt == CNT_LAST);
    assign drain_src_next = trunc_hit ? cur_src : drain_src;

    // Remember which source is being drained after a truncation.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) drain_src <= 1'b0;
        else                drain_src <= drain_src_next;
    end
`else
    assign trunc_hit      = 1'b0;
    assign drain_src_next = 1'b0;
`endif

    // State register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) state <= ARB_IDLE;
        else                state <= state_next;
    end

    // Next state: round-robin pick in IDLE, hold grant until the accepted TLAST.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (S0_AXIS_TVALID && S1_AXIS_TVALID) state_next = last_src ? ARB_GNT0 : ARB_GNT1;
                else if (S0_AXIS_TVALID)              state_next = ARB_GNT0;
                else if (S1_AXIS_TVALID)              state_next = ARB_GNT1;
            end
            ARB_GNT0, ARB_GNT1: begin
                if (acc && sel_last) state_next = ARB_IDLE;
`ifdef SATA_FRAMEARB_TRUNCATE_EN
                else if (trunc_hit)  state_next = ARB_DRAIN;
`endif
            end
`ifdef SATA_FRAMEARB_TRUNCATE_EN
            ARB_DRAIN: begin
                if (acc && sel_last) state_next = ARB_IDLE;
            end
`endif
            default: state_next = ARB_IDLE;
        endcase
    end

    // Output decode: source readies, selected word, and accept/forward strobes.
    always_comb begin
        S0_AXIS_TREADY = 1'b0;
        S1_AXIS_TREADY = 1'b0;
        sel_valid      = 1'b0;
        sel_ready      = 1'b0;
        sel_data       = S0_AXIS_TDATA;
        sel_last       = S0_AXIS_TLAST;
        cur_src        = 1'b0;
        fwd_en         = 1'b0;
        case (state)
            ARB_GNT0: begin
                S0_AXIS_TREADY = oreg_ready;
                sel_valid      = S0_AXIS_TVALID;
                sel_ready      = oreg_ready;
                fwd_en         = 1'b1;
            end
            ARB_GNT1: begin
                S1_AXIS_TREADY = oreg_ready;
                sel_valid      = S1_AXIS_TVALID;
                sel_ready      = oreg_ready;
                sel_data       = S1_AXIS_TDATA;
                sel_last       = S1_AXIS_TLAST;
                cur_src        = 1'b1;
                fwd_en         = 1'b1;
            end
`ifdef SATA_FRAMEARB_TRUNCATE_EN
            ARB_DRAIN: begin
                cur_src   = drain_src;
                sel_ready = 1'b1;
                if (drain_src) begin
                    S1_AXIS_TREADY = 1'b1;
                    sel_valid      = S1_AXIS_TVALID;
                    sel_last       = S1_AXIS_TLAST;
                end else begin
                    S0_AXIS_TREADY = 1'b1;
                    sel_valid      = S0_AXIS_TVALID;
                end
            end
`endif
            default: ;
        endcase
        acc = sel_valid && sel_ready;
        fwd = acc && fwd_en;
    end

    // Round-robin history, frame word counter and registered status outputs.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            last_src    <= 1'b1;
            cnt         <= '0;
            o_grant     <= '0;
            o_err_trunc <= 1'b0;
        end else begin
            if (acc && sel_last) last_src <= cur_src;
            if (state == ARB_IDLE) cnt <= '0;
            else if (acc)          cnt <= cnt + ARB_CNT_W'(1);
            o_grant     <= arb_grant(state_next, drain_src_next);
            o_err_trunc <= trunc_hit;
        end
    end

    sata_axis_oreg #(
        .W            (W),
        .OPT_LOWPOWER (OPT_LOWPOWER)
    ) u_oreg (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .s_valid   (fwd),
        .s_ready_c (oreg_ready),
        .s_data    (sel_data),
        .s_last    (sel_last || trunc_hit),
        .m_valid   (M_AXIS_TVALID),
        .m_ready   (M_AXIS_TREADY),
        .m_data    (M_AXIS_TDATA),
        .m_last    (M_AXIS_TLAST)
    );

endmodule
